// File: rtl/vproc_elem_pack.sv
// vproc_elem_pack: packs element-wise results (one element per cycle) into
// full vector-register lines and hands each line to writeback.
//
// Optional feature: define VPROC_ELEM_PACK_SAT_EN to clamp narrowed elements
// when the saturate flag is set. Otherwise narrowing is plain truncation and
// out_sat_o stays 0.
//
// Ports:
//   clk_i, async_rst_ni            clock, asynchronous active-low reset
//   in_valid_i / in_ready_o        element handshake
//   in_first_i / in_last_i         instruction boundaries
//   in_vaddr_i, in_eew_i           destination vreg and EEW (taken with first)
//   in_flags_i                     narrow / saturate / sig (taken with first)
//   in_elem_i, in_mask_i           element value and element write enable
//   out_valid_o / out_ready_i      packed line handshake
//   out_addr_o, out_data_o         line vreg address and data
//   out_be_o, out_sat_o            byte enables, any enabled element saturated

package vproc_elem_pack_pkg;
   typedef enum logic [1:0] {
      VSEW_8       = 2'd0,
      VSEW_16      = 2'd1,
      VSEW_32      = 2'd2,
      VSEW_INVALID = 2'd3
   } cfg_vsew;

   typedef struct packed {
      logic shift;
      logic shift_right;
      logic narrow;
      logic saturate;
      logic sig;
   } pack_flags;
endpackage

module vproc_elem_pack
   import vproc_elem_pack_pkg::*;
#(
   parameter int unsigned VREG_W = 128
) (
   input  logic                clk_i,
   input  logic                async_rst_ni,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic                in_first_i,
   input  logic                in_last_i,
   input  logic [4:0]          in_vaddr_i,
   input  cfg_vsew             in_eew_i,
   input  pack_flags           in_flags_i,
   input  logic [31:0]         in_elem_i,
   input  logic                in_mask_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [4:0]          out_addr_o,
   output logic [VREG_W-1:0]   out_data_o,
   output logic [VREG_W/8-1:0] out_be_o,
   output logic                out_sat_o
);

   localparam int unsigned BEW = VREG_W / 8;
   localparam int unsigned PW  = $clog2(BEW);

   logic [VREG_W-1:0] buf_data_q;
   logic [BEW-1:0]    buf_be_q;
   logic              buf_sat_q;
   logic [PW-1:0]     ptr_q;
   logic [4:0]        line_cnt_q;
   logic [4:0]        vaddr_q;
   cfg_vsew           eew_q;
   pack_flags         flags_q;

   logic              out_valid_q;
   logic [4:0]        out_addr_q;
   logic [VREG_W-1:0] out_data_q;
   logic [BEW-1:0]    out_be_q;
   logic              out_sat_q;

   // Effective configuration: a first element restarts the line and uses the
   // freshly presented config in the same cycle.
   cfg_vsew           eew_c;
   pack_flags         flags_c;
   logic [4:0]        vaddr_c;
   logic [VREG_W-1:0] base_data;
   logic [BEW-1:0]    base_be;
   logic              base_sat;
   logic [PW-1:0]     base_ptr;
   logic [4:0]        base_line;

   logic [31:0]       elem_val;
   logic [3:0]        ew_be4;
   logic [PW:0]       ew_step;
   logic              ew_valid;
   logic              sat_evt;

   logic [PW:0]       ptr_sum;
   logic              line_full;
   logic [BEW-1:0]    wr_be;
   logic [VREG_W-1:0] wr_bits;
   logic [VREG_W-1:0] elem_sh;
   logic [VREG_W-1:0] new_data;
   logic [BEW-1:0]    new_be;
   logic              new_sat;
   logic              accept;
   logic              flush;
   logic              unused_flags;

   assign in_ready_o  = !out_valid_q | out_ready_i;
   assign accept      = in_valid_i & in_ready_o;

   assign eew_c     = in_first_i ? in_eew_i   : eew_q;
   assign flags_c   = in_first_i ? in_flags_i : flags_q;
   assign vaddr_c   = in_first_i ? in_vaddr_i : vaddr_q;
   assign base_data = in_first_i ? '0 : buf_data_q;
   assign base_be   = in_first_i ? '0 : buf_be_q;
   assign base_sat  = in_first_i ? 1'b0 : buf_sat_q;
   assign base_ptr  = in_first_i ? '0 : ptr_q;
   assign base_line = in_first_i ? '0 : line_cnt_q;

   // Only narrow/saturate/sig matter here; the rest of the flags are sunk.
   assign unused_flags = ^flags_c;

   always_comb begin
      elem_val = in_elem_i;
      ew_be4   = 4'b0000;
      ew_step  = '0;
      ew_valid = 1'b1;
      sat_evt  = 1'b0;
      unique case (eew_c)
         VSEW_8: begin
            elem_val = {24'b0, in_elem_i[7:0]};
            ew_be4   = 4'b0001;
            ew_step  = (PW+1)'(1);
         end
         VSEW_16: begin
            elem_val = {16'b0, in_elem_i[15:0]};
            ew_be4   = 4'b0011;
            ew_step  = (PW+1)'(2);
         end
         VSEW_32: begin
            elem_val = in_elem_i;
            ew_be4   = 4'b1111;
            ew_step  = (PW+1)'(4);
         end
         default: ew_valid = 1'b0;
      endcase
`ifdef VPROC_ELEM_PACK_SAT_EN
      // Clamp the 2*SEW source into SEW; narrow at eew=32 is ignored.
      if (flags_c.narrow && flags_c.saturate) begin
         if (eew_c == VSEW_8) begin
            if (flags_c.sig) begin
               if (in_elem_i[15:7] != {9{in_elem_i[15]}}) begin
                  sat_evt  = 1'b1;
                  elem_val = {24'b0, in_elem_i[15] ? 8'h80 : 8'h7F};
               end
            end else if (in_elem_i[15:8] != 8'h00) begin
               sat_evt  = 1'b1;
               elem_val = 32'h0000_00FF;
            end
         end else if (eew_c == VSEW_16) begin
            if (flags_c.sig) begin
               if (in_elem_i[31:15] != {17{in_elem_i[31]}}) begin
                  sat_evt  = 1'b1;
                  elem_val = {16'b0, in_elem_i[31] ? 16'h8000 : 16'h7FFF};
               end
            end else if (in_elem_i[31:16] != 16'h0000) begin
               sat_evt  = 1'b1;
               elem_val = 32'h0000_FFFF;
            end
         end
      end
`endif
   end

   always_comb begin
      ptr_sum   = {1'b0, base_ptr} + ew_step;
      line_full = ptr_sum[PW];
      wr_be     = ew_valid ? (BEW'(ew_be4) << base_ptr) : '0;
      elem_sh   = VREG_W'(elem_val) << {base_ptr, 3'b000};
      wr_bits   = '0;
      for (int b = 0; b < int'(BEW); b++) begin
         wr_bits[b*8 +: 8] = {8{wr_be[b]}};
      end
      new_data  = (base_data & ~wr_bits) | (elem_sh & wr_bits);
      new_be    = base_be | (in_mask_i ? wr_be : '0);
      new_sat   = base_sat | (in_mask_i & ew_valid & sat_evt);
      flush     = accept & (line_full | in_last_i);
   end

   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         buf_data_q  <= '0;
         buf_be_q    <= '0;
         buf_sat_q   <= 1'b0;
         ptr_q       <= '0;
         line_cnt_q  <= '0;
         vaddr_q     <= '0;
         eew_q       <= VSEW_8;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_be_q    <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         if (accept) begin
            vaddr_q <= vaddr_c;
            eew_q   <= eew_c;
            flags_q <= flags_c;
            if (flush) begin
               buf_data_q <= '0;
               buf_be_q   <= '0;
               buf_sat_q  <= 1'b0;
               ptr_q      <= '0;
               line_cnt_q <= base_line + 5'd1;
            end else begin
               buf_data_q <= new_data;
               buf_be_q   <= new_be;
               buf_sat_q  <= new_sat;
               ptr_q      <= ptr_sum[PW-1:0];
               line_cnt_q <= base_line;
            end
         end
         // A flush can only be accepted when the output slot is free or being
         // drained this cycle, so the new line simply overwrites it.
         if (flush) begin
            out_valid_q <= 1'b1;
            out_addr_q  <= vaddr_c + base_line;
            out_data_q  <= new_data;
            out_be_q    <= new_be;
            out_sat_q   <= new_sat;
         end else if (out_valid_q && out_ready_i) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_be_q    <= '0;
            out_sat_q   <= 1'b0;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_addr_o  = out_addr_q;
   assign out_data_o  = out_data_q;
   assign out_be_o    = out_be_q;
   assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_vproc_elem_pack.sv
// Directed bench for vproc_elem_pack (VREG_W=128). Expectations for the
// saturation cases follow whichever build VPROC_ELEM_PACK_SAT_EN selects.
module tb_vproc_elem_pack;
   import vproc_elem_pack_pkg::*;

   logic         clk_i = 1'b0;
   logic         async_rst_ni = 1'b0;
   logic         in_valid_i = 1'b0;
   logic         in_ready_o;
   logic         in_first_i = 1'b0;
   logic         in_last_i = 1'b0;
   logic [4:0]   in_vaddr_i = '0;
   cfg_vsew      in_eew_i = VSEW_8;
   pack_flags    in_flags_i = '0;
   logic [31:0]  in_elem_i = '0;
   logic         in_mask_i = 1'b0;
   logic         out_valid_o;
   logic         out_ready_i = 1'b1;
   logic [4:0]   out_addr_o;
   logic [127:0] out_data_o;
   logic [15:0]  out_be_o;
   logic         out_sat_o;

   int nvec = 0;
   int nerr = 0;

   vproc_elem_pack #(.VREG_W(128)) dut (
      .clk_i        (clk_i),
      .async_rst_ni (async_rst_ni),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .in_first_i   (in_first_i),
      .in_last_i    (in_last_i),
      .in_vaddr_i   (in_vaddr_i),
      .in_eew_i     (in_eew_i),
      .in_flags_i   (in_flags_i),
      .in_elem_i    (in_elem_i),
      .in_mask_i    (in_mask_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_addr_o   (out_addr_o),
      .out_data_o   (out_data_o),
      .out_be_o     (out_be_o),
      .out_sat_o    (out_sat_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic cfg(input logic [4:0] va, input cfg_vsew e, input pack_flags f);
      in_vaddr_i = va;
      in_eew_i   = e;
      in_flags_i = f;
   endtask

   task automatic send(input logic [31:0] e, input logic m, input logic f, input logic l);
      in_valid_i = 1'b1;
      in_elem_i  = e;
      in_mask_i  = m;
      in_first_i = f;
      in_last_i  = l;
      step();
      in_valid_i = 1'b0;
      in_first_i = 1'b0;
      in_last_i  = 1'b0;
   endtask

   pack_flags fl;
   logic [127:0] exp_data;

   initial begin
      step();
      step();
      // reset state
      chk("rst_valid", out_valid_o, 1'b0);
      chk("rst_data", out_data_o, '0);
      chk("rst_be", out_be_o, '0);
      chk("rst_addr", out_addr_o, '0);
      chk("rst_sat", out_sat_o, 1'b0);
      chk("rst_ready", in_ready_o, 1'b1);
      async_rst_ni = 1'b1;
      step();

      // eew=32 single line
      cfg(5'd4, VSEW_32, '0);
      send(32'h11111111, 1'b1, 1'b1, 1'b0);
      send(32'h22222222, 1'b1, 1'b0, 1'b0);
      send(32'h33333333, 1'b1, 1'b0, 1'b0);
      chk("t1_no_early_valid", out_valid_o, 1'b0);
      send(32'h44444444, 1'b1, 1'b0, 1'b1);
      chk("t1_valid", out_valid_o, 1'b1);
      chk("t1_data", out_data_o, 128'h44444444_33333333_22222222_11111111);
      chk("t1_be", out_be_o, 16'hFFFF);
      chk("t1_addr", out_addr_o, 5'd4);
      chk("t1_sat", out_sat_o, 1'b0);
      step();
      chk("t1_drained_valid", out_valid_o, 1'b0);
      chk("t1_drained_be", out_be_o, '0);

      // eew=8, 20 elements, vaddr wraps 31 -> 0
      cfg(5'd31, VSEW_8, '0);
      for (int i = 0; i < 20; i++) begin
         send(32'(i), 1'b1, i == 0, i == 19);
         if (i == 15) begin
            chk("t2_l1_valid", out_valid_o, 1'b1);
            chk("t2_l1_data", out_data_o, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
            chk("t2_l1_be", out_be_o, 16'hFFFF);
            chk("t2_l1_addr", out_addr_o, 5'd31);
         end
      end
      chk("t2_l2_valid", out_valid_o, 1'b1);
      chk("t2_l2_data", out_data_o, 128'h13121110);
      chk("t2_l2_be", out_be_o, 16'h000F);
      chk("t2_l2_addr", out_addr_o, 5'd0);
      step();

      // eew=16 with alternating mask
      cfg(5'd7, VSEW_16, '0);
      for (int i = 0; i < 8; i++) begin
         send(32'hA000 + 32'(i), (i % 2) == 0, i == 0, i == 7);
      end
      chk("t3_be", out_be_o, 16'h3333);
      chk("t3_addr", out_addr_o, 5'd7);
      chk("t3_data", out_data_o & 128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF,
          128'h0000A006_0000A004_0000A002_0000A000);
      step();

      // narrowing, signed saturate
      fl = '0; fl.narrow = 1'b1; fl.saturate = 1'b1; fl.sig = 1'b1;
      cfg(5'd2, VSEW_8, fl);
      send(32'h0150, 1'b1, 1'b1, 1'b0);
      send(32'hFF00, 1'b1, 1'b0, 1'b1);
`ifdef VPROC_ELEM_PACK_SAT_EN
      chk("t4_sig_data", out_data_o, 128'h807F);
      chk("t4_sig_sat", out_sat_o, 1'b1);
`else
      chk("t4_sig_data", out_data_o, 128'h0050);
      chk("t4_sig_sat", out_sat_o, 1'b0);
`endif
      chk("t4_sig_be", out_be_o, 16'h0003);
      chk("t4_sig_addr", out_addr_o, 5'd2);
      step();

      // narrowing, unsigned saturate
      fl.sig = 1'b0;
      cfg(5'd2, VSEW_8, fl);
      send(32'h0150, 1'b1, 1'b1, 1'b1);
`ifdef VPROC_ELEM_PACK_SAT_EN
      chk("t4_uns_data", out_data_o, 128'hFF);
      chk("t4_uns_sat", out_sat_o, 1'b1);
`else
      chk("t4_uns_data", out_data_o, 128'h50);
      chk("t4_uns_sat", out_sat_o, 1'b0);
`endif
      step();

      // clamp on a masked-off element does not raise sat
      send(32'h0150, 1'b0, 1'b1, 1'b0);
      send(32'h0010, 1'b1, 1'b0, 1'b1);
      chk("t4_mask_be", out_be_o, 16'h0002);
      chk("t4_mask_sat", out_sat_o, 1'b0);
      chk("t4_mask_data", out_data_o & 128'hFF00, 128'h1000);
      step();

      // eew=16 signed saturate
      fl.sig = 1'b1;
      cfg(5'd9, VSEW_16, fl);
      send(32'h0001_8000, 1'b1, 1'b1, 1'b1);
`ifdef VPROC_ELEM_PACK_SAT_EN
      chk("t4_e16_data", out_data_o, 128'h7FFF);
      chk("t4_e16_sat", out_sat_o, 1'b1);
`else
      chk("t4_e16_data", out_data_o, 128'h8000);
      chk("t4_e16_sat", out_sat_o, 1'b0);
`endif
      chk("t4_e16_be", out_be_o, 16'h0003);
      step();

      // saturate without narrow leaves the value alone
      fl = '0; fl.saturate = 1'b1; fl.sig = 1'b1;
      cfg(5'd2, VSEW_8, fl);
      send(32'h0150, 1'b1, 1'b1, 1'b1);
      chk("t4_nonarrow_data", out_data_o, 128'h50);
      chk("t4_nonarrow_sat", out_sat_o, 1'b0);
      step();

      // backpressure: line held, next element stalled, order preserved
      out_ready_i = 1'b0;
      cfg(5'd10, VSEW_32, '0);
      send(32'hB0, 1'b1, 1'b1, 1'b0);
      send(32'hB1, 1'b1, 1'b0, 1'b0);
      send(32'hB2, 1'b1, 1'b0, 1'b0);
      send(32'hB3, 1'b1, 1'b0, 1'b0);
      exp_data = 128'h000000B3_000000B2_000000B1_000000B0;
      in_valid_i = 1'b1;
      in_elem_i  = 32'hB4;
      in_mask_i  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t5_stall_ready", in_ready_o, 1'b0);
         chk("t5_hold_valid", out_valid_o, 1'b1);
         chk("t5_hold_data", out_data_o, exp_data);
         chk("t5_hold_addr", out_addr_o, 5'd10);
      end
      out_ready_i = 1'b1;
      #1;
      chk("t5_release_ready", in_ready_o, 1'b1);
      step();
      in_valid_i = 1'b0;
      chk("t5_drain_valid", out_valid_o, 1'b0);
      send(32'hB5, 1'b1, 1'b0, 1'b0);
      send(32'hB6, 1'b1, 1'b0, 1'b0);
      send(32'hB7, 1'b1, 1'b0, 1'b0);
      chk("t5_l2_valid", out_valid_o, 1'b1);
      chk("t5_l2_data", out_data_o, 128'h000000B7_000000B6_000000B5_000000B4);
      chk("t5_l2_addr", out_addr_o, 5'd11);
      step();

      // flush and handshake in the same cycle, back to back
      cfg(5'd30, VSEW_32, '0);
      send(32'hAAA0, 1'b1, 1'b1, 1'b1);
      chk("t6_l0_valid", out_valid_o, 1'b1);
      chk("t6_l0_addr", out_addr_o, 5'd30);
      send(32'hAAA1, 1'b1, 1'b0, 1'b1);
      chk("t6_l1_valid", out_valid_o, 1'b1);
      chk("t6_l1_data", out_data_o, 128'hAAA1);
      chk("t6_l1_be", out_be_o, 16'h000F);
      chk("t6_l1_addr", out_addr_o, 5'd31);
      send(32'hAAA2, 1'b1, 1'b0, 1'b1);
      chk("t6_l2_valid", out_valid_o, 1'b1);
      chk("t6_l2_data", out_data_o, 128'hAAA2);
      chk("t6_l2_addr", out_addr_o, 5'd0);
      step();
      chk("t6_idle_valid", out_valid_o, 1'b0);

      // async reset with a pending output line
      out_ready_i = 1'b0;
      cfg(5'd3, VSEW_32, '0);
      send(32'hC0, 1'b1, 1'b1, 1'b0);
      send(32'hC1, 1'b1, 1'b0, 1'b0);
      send(32'hC2, 1'b1, 1'b0, 1'b0);
      send(32'hC3, 1'b1, 1'b0, 1'b0);
      chk("t7_pending_valid", out_valid_o, 1'b1);
      async_rst_ni = 1'b0;
      #1;
      chk("t7_rst_valid", out_valid_o, 1'b0);
      chk("t7_rst_data", out_data_o, '0);
      chk("t7_rst_be", out_be_o, '0);
      chk("t7_rst_addr", out_addr_o, '0);
      step();
      async_rst_ni = 1'b1;
      out_ready_i = 1'b1;

      // async reset after 2 of 4 elements
      send(32'hD0, 1'b1, 1'b1, 1'b0);
      send(32'hD1, 1'b1, 1'b0, 1'b0);
      async_rst_ni = 1'b0;
      #1;
      chk("t7_mid_valid", out_valid_o, 1'b0);
      step();
      async_rst_ni = 1'b1;
      step();
      chk("t7_no_line", out_valid_o, 1'b0);
      cfg(5'd5, VSEW_32, '0);
      send(32'hE0, 1'b1, 1'b1, 1'b0);
      send(32'hE1, 1'b1, 1'b0, 1'b0);
      send(32'hE2, 1'b1, 1'b0, 1'b0);
      send(32'hE3, 1'b1, 1'b0, 1'b1);
      chk("t7_clean_valid", out_valid_o, 1'b1);
      chk("t7_clean_data", out_data_o, 128'h000000E3_000000E2_000000E1_000000E0);
      chk("t7_clean_be", out_be_o, 16'hFFFF);
      chk("t7_clean_addr", out_addr_o, 5'd5);
      chk("t7_clean_sat", out_sat_o, 1'b0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
